// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and default widths for the MAC job sequencer.
package mac_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default activation/weight width, partial-sum width and job-length width.
  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned LEN_BW  = 8;

endpackage

// File: rtl/mac.sv
// mac: combinational multiply-add, out = c + {0,a} * b, wrapping modulo 2**psum_bw.
// The activation is unsigned and the weight signed; the bw+1 x bw signed product
// is sign-extended (or truncated) to psum_bw before the add.
module mac
  import mac_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned psum_bw = PSUM_BW
) (
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);

  localparam int unsigned PROD_W = 2 * bw + 1;

  logic signed [bw:0]       a_s;
  logic signed [bw-1:0]     b_s;
  logic signed [PROD_W-1:0] prod;

  // Exact signed product, then wrap-around accumulate at psum width.
  always_comb begin
    a_s  = $signed({1'b0, a});
    b_s  = $signed(b);
    prod = PROD_W'(a_s) * PROD_W'(b_s);
    out  = c + psum_bw'(prod);
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for one MAC datapath cell.
// Accepts a job of len beats, accumulates a_in*b_in into a feedback psum
// register and presents the final psum on a valid/ready output.
// Optional feature: define MAC_SEQ_RELU_EN to clamp negative results to zero
// at the output register; the internal accumulation is unaffected.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned bw      = BW,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned len_bw  = LEN_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      a_in,
  input  logic [bw-1:0]      b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum
);

  state_t              state;
  logic [len_bw-1:0]   len_q;
  logic [len_bw-1:0]   cnt;
  logic [psum_bw-1:0]  psum;
  logic [psum_bw-1:0]  mac_out;
  logic [psum_bw-1:0]  result_c;
  logic                beat_c;
  logic                last_c;

  // Single multiply-add, fed back from the psum register.
  mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a   (a_in),
    .b   (b_in),
    .c   (psum),
    .out (mac_out)
  );

  // in_ready is high only in ACC, so a handshake implies ACC.
  assign beat_c = in_valid && in_ready;
  assign last_c = (cnt == len_q - len_bw'(1));

  // Value loaded into the output register on the final beat.
`ifdef MAC_SEQ_RELU_EN
  assign result_c = mac_out[psum_bw-1] ? '0 : mac_out;
`else
  assign result_c = mac_out;
`endif

  // Sequencer FSM with counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      psum      <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_psum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            psum  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            if (len == '0) begin
              // Empty job: result is zero, skip accumulation entirely.
              state     <= DONE;
              out_valid <= 1'b1;
              out_psum  <= '0;
            end else begin
              state    <= ACC;
              in_ready <= 1'b1;
            end
          end
        end

        ACC: begin
          if (beat_c) begin
            psum <= mac_out;
            cnt  <= cnt + len_bw'(1);
            if (last_c) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_psum  <= result_c;
            end
          end
        end

        DONE: begin
          // Result held stable until downstream accepts it; start ignored here.
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs track the state they are defined by.
  ap_ready_in_acc : assert property (@(posedge clk) disable iff (reset)
    in_ready == (state == ACC));
  ap_valid_in_done : assert property (@(posedge clk) disable iff (reset)
    out_valid == (state == DONE));
  ap_busy_state : assert property (@(posedge clk) disable iff (reset)
    busy == (state != IDLE));

  // A stalled result must not change.
  ap_out_stable : assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_psum)));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized and directed checks of mac_seq_ctrl against a
// reference model computing the dot product with plain integer arithmetic.
// A second instance with psum_bw=8 runs in lockstep to cover narrow wrap-around.
module tb_mac_seq_ctrl;

  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned PSUM8   = 8;
  localparam int unsigned LEN_BW  = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_BW-1:0]  len;
  logic               in_valid;
  logic [BW-1:0]      a_in;
  logic [BW-1:0]      b_in;
  logic               out_ready;

  logic               busy;
  logic               in_ready;
  logic               out_valid;
  logic [PSUM_BW-1:0] out_psum;

  logic               busy8;
  logic               in_ready8;
  logic               out_valid8;
  logic [PSUM8-1:0]   out_psum8;

  int n_checks = 0;
  int n_errors = 0;

  // Beats of the job about to run: activation 0..15, weight -8..7.
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .bw      (BW),
    .psum_bw (PSUM_BW),
    .len_bw  (LEN_BW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum)
  );

  mac_seq_ctrl #(
    .bw      (BW),
    .psum_bw (PSUM8),
    .len_bw  (LEN_BW)
  ) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy8),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_psum  (out_psum8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Exact dot product of the queued beats.
  function automatic longint model_sum();
    longint s = 0;
    foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
    return s;
  endfunction

  // Result as seen on a w-bit output: wrap modulo 2**w, optional ReLU.
  function automatic logic [31:0] model_out(input longint s, input int w);
    longint m;
    m = s & ((longint'(1) << w) - 1);
`ifdef MAC_SEQ_RELU_EN
    if (m[w-1]) m = 0;
`endif
    return 32'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one job from IDLE: n beats from qa/qb, gap idle cycles between beats
  // (negative = random 0..3), hold cycles of out_ready=0 in DONE. misuse pulses
  // start during ACC gaps; hold_start keeps start high through the DONE exit.
  task automatic run_job(input int n, input int gap, input int hold,
                         input bit misuse, input bit hold_start);
    longint      s;
    logic [31:0] e16;
    logic [31:0] e8;
    int          g;
    s   = model_sum();
    e16 = model_out(s, PSUM_BW);
    e8  = model_out(s, PSUM8);

    start    = 1'b1;
    len      = LEN_BW'(n);
    in_valid = 1'($urandom);
    a_in     = BW'($urandom);
    b_in     = BW'($urandom);
    tick();
    start = 1'b0;
    len   = LEN_BW'($urandom);

    if (n == 0) begin
      check_eq("empty_valid", 32'(out_valid), 32'd1);
      check_eq("empty_ready", 32'(in_ready), 32'd0);
      check_eq("empty_busy", 32'(busy), 32'd1);
    end else begin
      check_eq("acc_entry_ready", 32'(in_ready), 32'd1);
      check_eq("acc_entry_ready8", 32'(in_ready8), 32'd1);
      check_eq("acc_entry_busy", 32'(busy), 32'd1);
      check_eq("acc_entry_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < n; i++) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          a_in     = BW'($urandom);
          b_in     = BW'($urandom);
          start    = misuse ? 1'($urandom) : 1'b0;
          len      = LEN_BW'($urandom);
          tick();
        end
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = BW'(qa[i]);
        b_in     = BW'(qb[i]);
        tick();
        in_valid = 1'b0;
        if (i < n - 1) begin
          check_eq("acc_mid_ready", 32'(in_ready), 32'd1);
          check_eq("acc_mid_valid", 32'(out_valid), 32'd0);
        end
      end
      check_eq("done_valid", 32'(out_valid), 32'd1);
      check_eq("done_ready", 32'(in_ready), 32'd0);
      check_eq("done_busy", 32'(busy), 32'd1);
    end
    check_eq("done_psum16", 32'(out_psum), e16);
    check_eq("done_valid8", 32'(out_valid8), 32'd1);
    check_eq("done_busy8", 32'(busy8), 32'd1);
    check_eq("done_psum8", 32'(out_psum8), e8);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      a_in      = BW'($urandom);
      b_in      = BW'($urandom);
      start     = misuse ? 1'($urandom) : 1'b0;
      tick();
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_psum16", 32'(out_psum), e16);
    end

    out_ready = 1'b1;
    start     = hold_start;
    len       = LEN_BW'($urandom_range(1, 5));
    in_valid  = 1'($urandom);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("idle_valid", 32'(out_valid), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic set_beats(input int n, input int a, input int b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_psum", 32'(out_psum), 32'd0);

    // Mixed-sign beats: -233, wraps to 0x17 at 8 bits.
    qa = '{15, 15, 1};
    qb = '{-8, -8, 7};
    run_job(3, 0, 0, 1'b0, 1'b0);

    // Bubbles of two cycles between beats, then a five-cycle stall.
    set_beats(4, 2, 3);
    run_job(4, 2, 5, 1'b0, 1'b0);

    // Empty job.
    qa.delete();
    qb.delete();
    run_job(0, 0, 1, 1'b0, 1'b0);

    // 315: wraps to 0x3B on the 8-bit instance.
    set_beats(3, 15, 7);
    run_job(3, 0, 0, 1'b0, 1'b0);

    // Negative result left in the output register before the reset test.
    set_beats(2, 9, -5);
    run_job(2, 0, 0, 1'b0, 1'b0);

    // Reset asserted mid-ACC, two beats into a five-beat job.
    start = 1'b1;
    len   = LEN_BW'(5);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = BW'(3);
    b_in     = BW'(3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_psum", 32'(out_psum), 32'd0);
    check_eq("midrst_psum_reg", 32'(u_dut.psum), 32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("postrst_busy", 32'(busy), 32'd0);
    check_eq("postrst_in_ready", 32'(in_ready), 32'd0);

    // Fresh job after reset; start pulses during ACC and start held into IDLE.
    qa = '{7, 0, 12, 5};
    qb = '{-1, 6, 3, -8};
    run_job(4, 2, 2, 1'b1, 1'b1);
    set_beats(2, 4, 4);
    run_job(2, 1, 0, 1'b1, 1'b1);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      n = (j % 10 == 9) ? int'($urandom_range(30, 80)) : int'($urandom_range(0, 12));
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 15)));
        qb.push_back(int'($urandom_range(0, 15)) - 8);
      end
      run_job(n, -1, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    start = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
